// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: layer schedule controller for the PE array.
// Runs filter load, per-set ifmap load, compute, and ifmap reload for every
// output strip. All outputs are registered copies of next-state decodes.
module pe_array_sequencer #(
  parameter int ROWS = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [4:0]      p,
  input  logic [4:0]      q,
  input  logic [4:0]      t,
  input  logic [4:0]      r,
  input  logic [4:0]      R,
  input  logic [4:0]      S,
  input  logic [15:0]     H,
  input  logic [15:0]     W,
  input  logic            complete,
  output logic [ROWS-1:0] load_signal,
  output logic [ROWS-1:0] load_signal2,
  output logic [ROWS-1:0] load_signal3,
  output logic [ROWS-2:0] mux_sel,
  output logic            start,
  output logic            busy,
  output logic            all_done,
  output logic            cfg_err
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FILT  = 3'd1,
    ST_LOAD_IFMAP = 3'd2,
    ST_RUN        = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // Low n bits set, saturating at the array height.
  function automatic logic [ROWS-1:0] low_mask(input logic [14:0] n);
    logic [ROWS-1:0] m;
    for (int i = 0; i < ROWS; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  // Row i is the top of a PE set when (i+1) is a multiple of the set height
  // and another active set sits above it.
  function automatic logic [ROWS-2:0] set_top_map(input logic [4:0] rlen,
                                                  input logic [14:0] rows);
    logic [ROWS-2:0] m;
    m = {(ROWS-1){1'b0}};
    if (rlen != 5'd0) begin
      for (int i = 0; i < ROWS - 1; i++) begin
        m[i] = (((i + 1) % int'(rlen)) == 32'sd0) && ((i + 1) < int'(rows));
      end
    end else begin
      m = {(ROWS-1){1'b0}};
    end
    return m;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [14:0]     cnt_r, cnt_nxt_s;
  logic [9:0]      k_r, k_nxt_s;
  logic [15:0]     strip_r, strip_nxt_s;
  logic [ROWS-1:0] win_r, win_nxt_s;

  logic [4:0]      rlen_r;
  logic [9:0]      nsets_r;
  logic [14:0]     flen_r;
  logic [9:0]      ilen_r;
  logic [15:0]     nstrip_r;
  logic [ROWS-1:0] setmask_r;
  logic [ROWS-1:0] actmask_r;

  logic [9:0]      nsets_in_s;
  logic [14:0]     rows_in_s;
  logic [14:0]     flen_in_s;
  logic [9:0]      ilen_in_s;
  logic [15:0]     nstrip_in_s;
  logic            cfg_ok_s;
  logic            accept_s;
  logic            reject_s;
  logic [ROWS-1:0] act_cur_s;
  logic [ROWS-1:0] ls_nxt_s, ls2_nxt_s, ls3_nxt_s;
  logic [ROWS-2:0] mux_nxt_s;
  logic            unused_h_s;

  // Ifmap height is carried for the interface but not needed for sequencing.
  assign unused_h_s = ^H;

  assign nsets_in_s  = {5'd0, r} * {5'd0, t};
  assign rows_in_s   = {5'd0, nsets_in_s} * {10'd0, R};
  assign flen_in_s   = {10'd0, S} * {10'd0, p} * {10'd0, q};
  assign ilen_in_s   = {5'd0, S} * {5'd0, q};
  assign nstrip_in_s = W - {11'd0, S} + 16'd1;
  assign cfg_ok_s    = (R != 5'd0) && (rows_in_s <= 15'(ROWS)) &&
                       (nsets_in_s != 10'd0) && (flen_in_s != 15'd0) &&
                       (ilen_in_s != 10'd0) && (W >= {11'd0, S});

  // Next-state, counter updates and next output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    k_nxt_s     = k_r;
    strip_nxt_s = strip_r;
    win_nxt_s   = win_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go && cfg_ok_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LOAD_FILT;
          cnt_nxt_s   = 15'd0;
          strip_nxt_s = 16'd0;
        end else if (go) begin
          reject_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_FILT: begin
        if (cnt_r == flen_r - 15'd1) begin
          state_nxt_s = ST_LOAD_IFMAP;
          cnt_nxt_s   = 15'd0;
          k_nxt_s     = 10'd0;
          win_nxt_s   = setmask_r;
        end else begin
          cnt_nxt_s = cnt_r + 15'd1;
        end
      end
      ST_LOAD_IFMAP: begin
        if (cnt_r == {5'd0, ilen_r} - 15'd1) begin
          cnt_nxt_s = 15'd0;
          if (k_r + 10'd1 == nsets_r) begin
            state_nxt_s = ST_RUN;
          end else begin
            k_nxt_s   = k_r + 10'd1;
            win_nxt_s = win_r << rlen_r;
          end
        end else begin
          cnt_nxt_s = cnt_r + 15'd1;
        end
      end
      ST_RUN: begin
        if (complete) begin
          strip_nxt_s = strip_r + 16'd1;
          if (strip_r + 16'd1 == nstrip_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD_IFMAP;
            cnt_nxt_s   = 15'd0;
            k_nxt_s     = 10'd0;
            win_nxt_s   = setmask_r;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // On the accepting edge the latched masks are not yet valid, so use the
    // values derived straight from the inputs.
    act_cur_s = accept_s ? low_mask(rows_in_s) : actmask_r;
    if (state_nxt_s == ST_LOAD_FILT || state_nxt_s == ST_LOAD_IFMAP) begin
      ls_nxt_s = act_cur_s;
    end else begin
      ls_nxt_s = {ROWS{1'b0}};
    end
    ls2_nxt_s = (state_nxt_s == ST_LOAD_IFMAP) ? win_nxt_s : {ROWS{1'b0}};
    ls3_nxt_s = (state_nxt_s == ST_LOAD_FILT) ? act_cur_s : {ROWS{1'b0}};
    if (accept_s) begin
      mux_nxt_s = set_top_map(R, rows_in_s);
    end else if (state_nxt_s == ST_IDLE) begin
      mux_nxt_s = {(ROWS-1){1'b0}};
    end else begin
      mux_nxt_s = mux_sel;
    end
  end

  // State and schedule counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 15'd0;
      k_r     <= 10'd0;
      strip_r <= 16'd0;
      win_r   <= {ROWS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      k_r     <= k_nxt_s;
      strip_r <= strip_nxt_s;
      win_r   <= win_nxt_s;
    end
  end

  // Latched layer configuration; only updated by an accepted go.
  always_ff @(posedge clk) begin
    if (rst) begin
      rlen_r    <= 5'd0;
      nsets_r   <= 10'd0;
      flen_r    <= 15'd0;
      ilen_r    <= 10'd0;
      nstrip_r  <= 16'd0;
      setmask_r <= {ROWS{1'b0}};
      actmask_r <= {ROWS{1'b0}};
    end else if (accept_s) begin
      rlen_r    <= R;
      nsets_r   <= nsets_in_s;
      flen_r    <= flen_in_s;
      ilen_r    <= ilen_in_s;
      nstrip_r  <= nstrip_in_s;
      setmask_r <= low_mask({10'd0, R});
      actmask_r <= low_mask(rows_in_s);
    end
  end

  // Registered array controls and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_signal  <= {ROWS{1'b0}};
      load_signal2 <= {ROWS{1'b0}};
      load_signal3 <= {ROWS{1'b0}};
      mux_sel      <= {(ROWS-1){1'b0}};
      start        <= 1'b0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      load_signal  <= ls_nxt_s;
      load_signal2 <= ls2_nxt_s;
      load_signal3 <= ls3_nxt_s;
      mux_sel      <= mux_nxt_s;
      start        <= (state_nxt_s == ST_RUN);
      busy         <= (state_nxt_s != ST_IDLE);
      all_done     <= (state_nxt_s == ST_DONE);
      cfg_err      <= reject_s;
    end
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed self-checking bench for pe_array_sequencer.
module tb_pe_array_sequencer;

  logic        clk;
  logic        rst;
  logic        go;
  logic [4:0]  p, q, t, r, R, S;
  logic [15:0] H, W;
  logic        complete;
  logic [11:0] load_signal, load_signal2, load_signal3;
  logic [10:0] mux_sel;
  logic        start, busy, all_done, cfg_err;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  localparam logic [47:0] WIN_BASIC = {12'he00, 12'h1c0, 12'h038, 12'h007};
  localparam logic [47:0] WIN_EDGE  = {36'h0, 12'hfff};

  pe_array_sequencer #(.ROWS(12)) dut (
    .clk(clk), .rst(rst), .go(go),
    .p(p), .q(q), .t(t), .r(r), .R(R), .S(S), .H(H), .W(W),
    .complete(complete),
    .load_signal(load_signal), .load_signal2(load_signal2),
    .load_signal3(load_signal3), .mux_sel(mux_sel),
    .start(start), .busy(busy), .all_done(all_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    checks_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int rv_big, input int rv, input int tv,
                         input int sv, input int pv, input int qv, input int wv);
    R = 5'(rv_big); r = 5'(rv); t = 5'(tv);
    S = 5'(sv); p = 5'(pv); q = 5'(qv);
    W = 16'(wv); H = 16'd7;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_ls"},   32'(load_signal),  32'h0);
    check_val({tag, "_ls2"},  32'(load_signal2), 32'h0);
    check_val({tag, "_ls3"},  32'(load_signal3), 32'h0);
    check_val({tag, "_mux"},  32'(mux_sel),      32'h0);
    check_val({tag, "_start"},32'(start),        32'h0);
    check_val({tag, "_busy"}, 32'(busy),         32'h0);
    check_val({tag, "_done"}, 32'(all_done),     32'h0);
    check_val({tag, "_err"},  32'(cfg_err),      32'h0);
  endtask

  task automatic filt_phase(input int flen, input logic [11:0] act);
    for (int c = 0; c < flen; c++) begin
      check_val("filt_ls3",   32'(load_signal3), 32'(act));
      check_val("filt_ls",    32'(load_signal),  32'(act));
      check_val("filt_ls2",   32'(load_signal2), 32'h0);
      check_val("filt_busy",  32'(busy),         32'h1);
      check_val("filt_start", 32'(start),        32'h0);
      tick();
    end
  endtask

  task automatic ifmap_phase(input int nsets, input int ilen,
                             input logic [47:0] wins, input logic [11:0] act);
    for (int s = 0; s < nsets; s++) begin
      for (int c = 0; c < ilen; c++) begin
        check_val("ifm_ls2",   32'(load_signal2), 32'(wins[s*12 +: 12]));
        check_val("ifm_ls",    32'(load_signal),  32'(act));
        check_val("ifm_ls3",   32'(load_signal3), 32'h0);
        check_val("ifm_start", 32'(start),        32'h0);
        check_val("ifm_done",  32'(all_done),     32'h0);
        tick();
      end
    end
    check_val("run_start", 32'(start),        32'h1);
    check_val("run_ls",    32'(load_signal),  32'h0);
    check_val("run_ls2",   32'(load_signal2), 32'h0);
    check_val("run_ls3",   32'(load_signal3), 32'h0);
  endtask

  task automatic run_hold(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check_val("run_hold_start", 32'(start), 32'h1);
      check_val("run_hold_busy",  32'(busy),  32'h1);
    end
  endtask

  task automatic complete_pulse();
    complete = 1'b1;
    tick();
    complete = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; complete = 1'b0;
    set_cfg(3, 2, 2, 3, 1, 2, 5);
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");
    tick();
    check_idle("idle_hold");

    // Basic layer: 4 sets of 3 rows, FLEN=6, ILEN=6, 3 strips.
    go = 1'b1;
    tick();
    go = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    check_val("basic_err", 32'(cfg_err), 32'h0);
    check_val("basic_mux", 32'(mux_sel), 32'h124);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 complete = 1'b1;
        @(posedge clk);
        #1 complete = 1'b0;
      end
    join_none
    filt_phase(6, 12'hfff);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 complete = 1'b1;
        @(posedge clk);
        #1 complete = 1'b0;
      end
    join_none
    ifmap_phase(4, 6, WIN_BASIC, 12'hfff);
    check_val("basic_mux_run", 32'(mux_sel), 32'h124);
    run_hold(3);
    // complete held for four cycles counts once
    complete = 1'b1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 complete = 1'b0;
      end
    join_none
    tick();
    check_val("held_start", 32'(start),    32'h0);
    check_val("held_done",  32'(all_done), 32'h0);
    ifmap_phase(4, 6, WIN_BASIC, 12'hfff);
    run_hold(2);
    // go while busy must be ignored
    set_cfg(12, 1, 1, 1, 1, 1, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_val("busy_go_err",   32'(cfg_err), 32'h0);
    check_val("busy_go_start", 32'(start),   32'h1);
    complete_pulse();
    ifmap_phase(4, 6, WIN_BASIC, 12'hfff);
    run_hold(1);
    complete_pulse();
    check_val("basic_done",      32'(all_done), 32'h1);
    check_val("basic_done_busy", 32'(busy),     32'h1);
    check_val("basic_done_st",   32'(start),    32'h0);
    tick();
    check_idle("after_basic");

    // Rejection: 15 rows
    set_cfg(5, 1, 3, 3, 1, 1, 5);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_val("rej_rows_err",  32'(cfg_err),      32'h1);
    check_val("rej_rows_busy", 32'(busy),         32'h0);
    check_val("rej_rows_ls3",  32'(load_signal3), 32'h0);
    tick();
    check_val("rej_rows_err2",  32'(cfg_err), 32'h0);
    check_val("rej_rows_busy2", 32'(busy),    32'h0);

    // Rejection: W < S
    set_cfg(3, 2, 2, 3, 1, 2, 2);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_val("rej_w_err",  32'(cfg_err), 32'h1);
    check_val("rej_w_busy", 32'(busy),    32'h0);
    tick();
    check_idle("after_rej");

    // Reset during set-2 ifmap load, with complete in the same cycle
    set_cfg(3, 2, 2, 3, 1, 2, 5);
    go = 1'b1;
    tick();
    go = 1'b0;
    filt_phase(6, 12'hfff);
    repeat (14) tick();
    check_val("pre_rst_ls2", 32'(load_signal2), 32'h1c0);
    rst = 1'b1;
    complete = 1'b1;
    tick();
    rst = 1'b0;
    complete = 1'b0;
    check_idle("mid_rst");
    tick();
    check_idle("mid_rst_hold");

    // Fresh layer after reset, single strip (W=S)
    set_cfg(3, 2, 2, 3, 1, 2, 3);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_val("fresh_mux", 32'(mux_sel), 32'h124);
    filt_phase(6, 12'hfff);
    ifmap_phase(4, 6, WIN_BASIC, 12'hfff);
    run_hold(2);
    complete_pulse();
    check_val("fresh_done", 32'(all_done), 32'h1);
    tick();
    check_idle("after_fresh");

    // Edge config: one 12-row set, FLEN=ILEN=NSTRIP=1
    set_cfg(12, 1, 1, 1, 1, 1, 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_val("edge_mux",  32'(mux_sel), 32'h0);
    check_val("edge_busy", 32'(busy),    32'h1);
    filt_phase(1, 12'hfff);
    ifmap_phase(1, 1, WIN_EDGE, 12'hfff);
    run_hold(1);
    complete_pulse();
    check_val("edge_done",  32'(all_done), 32'h1);
    check_val("edge_start", 32'(start),    32'h0);
    tick();
    check_idle("after_edge");

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
